// File: rtl/vert_subpel_filter.sv
// Vertical HEVC luma 8-tap sub-pel filter: sliding 8-row window, MAC stage, round/clip stage.
// Optional macro SUBPEL_SAT_CNT_EN adds sat_cnt, a saturating count of clipped output lanes.
module vert_subpel_filter #(
  parameter int NUM_PIXEL = 8,
  parameter int PIXEL_W   = 8,
  parameter int BLK_ROWS  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_PIXEL*PIXEL_W-1:0] in_row,
  input  logic [1:0]                   frac_sel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_PIXEL*PIXEL_W-1:0] out_row,
  output logic                         block_done,
  output logic                         busy
`ifdef SUBPEL_SAT_CNT_EN
  ,
  output logic [15:0]                  sat_cnt
`endif
);
  localparam int ROW_W   = NUM_PIXEL * PIXEL_W;
  localparam int COEF_W  = 8;
  localparam int ACC_W   = 16;
  localparam int TAPS    = 8;
  localparam int IN_ROWS = BLK_ROWS + TAPS - 1;
  localparam int RCNT_W  = $clog2(IN_ROWS + 1);
  localparam int OCNT_W  = $clog2(BLK_ROWS + 1);
  localparam int PIX_MAX = (1 << PIXEL_W) - 1;

  // Tap tables packed w7 (MSB) .. w0 (LSB), two's complement.
  localparam logic [TAPS*COEF_W-1:0] TAPS_A = {8'h00, 8'h01, 8'hFB, 8'h11, 8'h3A, 8'hF6, 8'h04, 8'hFF};
  localparam logic [TAPS*COEF_W-1:0] TAPS_B = {8'hFF, 8'h04, 8'hF5, 8'h28, 8'h28, 8'hF5, 8'h04, 8'hFF};
  localparam logic [TAPS*COEF_W-1:0] TAPS_C = {8'hFF, 8'h04, 8'hF6, 8'h3A, 8'h11, 8'hFB, 8'h01, 8'h00};
  localparam logic [TAPS*COEF_W-1:0] TAPS_F = {8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  function automatic logic signed [COEF_W-1:0] coef(input logic [1:0] f, input int t);
    logic [TAPS*COEF_W-1:0] tbl;
    case (f)
      2'd0:    tbl = TAPS_A;
      2'd1:    tbl = TAPS_B;
      2'd2:    tbl = TAPS_C;
      default: tbl = TAPS_F;
    endcase
    return $signed(tbl[t*COEF_W +: COEF_W]);
  endfunction

  function automatic logic signed [ACC_W-1:0] mul_tap(input logic [PIXEL_W-1:0] p,
                                                      input logic signed [COEF_W-1:0] c);
    logic signed [ACC_W-1:0] ps;
    logic signed [ACC_W-1:0] cs;
    ps = $signed({{(ACC_W-PIXEL_W){1'b0}}, p});
    cs = $signed({{(ACC_W-COEF_W){c[COEF_W-1]}}, c});
    return ps * cs;
  endfunction

  function automatic logic signed [ACC_W-1:0] round_sh(input logic signed [ACC_W-1:0] acc);
    return (acc + $signed(ACC_W'(32))) >>> 6;
  endfunction

  function automatic logic [PIXEL_W-1:0] clip_pix(input logic signed [ACC_W-1:0] r);
    if (r < 0) return '0;
    if (r > $signed(ACC_W'(PIX_MAX))) return PIXEL_W'(PIX_MAX);
    return r[PIXEL_W-1:0];
  endfunction

  state_t                  state_q, state_d;
  logic [RCNT_W-1:0]       row_cnt_q, row_cnt_d;
  logic [OCNT_W-1:0]       out_cnt_q, out_cnt_d;
  logic [1:0]              frac_q, frac_d;
  logic                    rdy_en_q;
  logic [ROW_W-1:0]        win_q [TAPS];
  logic [ROW_W-1:0]        src [TAPS];
  logic                    adv, in_acc, out_acc, launch;
  logic signed [ACC_W-1:0] mac_d [NUM_PIXEL];
  logic signed [ACC_W-1:0] acc_p0_q [NUM_PIXEL];
  logic                    vld_p0_q;
  logic [ROW_W-1:0]        row_p1_d, row_p1_q;
  logic                    vld_p1_q;
`ifdef SUBPEL_SAT_CNT_EN
  logic [NUM_PIXEL-1:0]    clip_p1_d, clip_p1_q;
  logic [15:0]             sat_cnt_q, sat_cnt_d;
  logic [16:0]             sat_sum;
`endif

  assign adv        = !vld_p1_q || out_ready;
  assign in_ready   = rdy_en_q && adv && (state_q != DRAIN);
  assign in_acc     = in_valid && in_ready;
  assign out_acc    = vld_p1_q && out_ready;
  assign launch     = in_acc && (state_q == RUN);
  assign out_valid  = vld_p1_q;
  assign out_row    = row_p1_q;
  assign busy       = (state_q != IDLE);
  assign block_done = (state_q == DRAIN) && out_acc && (out_cnt_q == OCNT_W'(BLK_ROWS - 1));

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    frac_d    = frac_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      IDLE: if (in_acc) begin
        frac_d    = frac_sel;
        row_cnt_d = RCNT_W'(1);
        state_d   = FILL;
      end
      FILL: if (in_acc) begin
        row_cnt_d = row_cnt_q + RCNT_W'(1);
        if (row_cnt_d == RCNT_W'(TAPS - 1)) state_d = RUN;
      end
      RUN: if (in_acc) begin
        if (row_cnt_q == RCNT_W'(IN_ROWS - 1)) begin
          row_cnt_d = '0;
          state_d   = DRAIN;
        end else begin
          row_cnt_d = row_cnt_q + RCNT_W'(1);
        end
      end
      DRAIN: if (block_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (out_acc)
      out_cnt_d = (out_cnt_q == OCNT_W'(BLK_ROWS - 1)) ? '0 : out_cnt_q + OCNT_W'(1);
  end

  // Window as it stands once the incoming row is shifted in; the MAC sees the new row directly.
  always_comb begin
    for (int t = 0; t < TAPS - 1; t++) src[t] = win_q[t+1];
    src[TAPS-1] = in_row;
  end

  always_comb begin
    for (int l = 0; l < NUM_PIXEL; l++) begin
      logic signed [ACC_W-1:0] sum;
      sum = '0;
      for (int t = 0; t < TAPS; t++)
        sum = sum + mul_tap(src[t][l*PIXEL_W +: PIXEL_W], coef(frac_q, t));
      mac_d[l] = sum;
    end
  end

  always_comb begin
    row_p1_d = '0;
`ifdef SUBPEL_SAT_CNT_EN
    clip_p1_d = '0;
`endif
    for (int l = 0; l < NUM_PIXEL; l++) begin
      logic signed [ACC_W-1:0] r;
      r = round_sh(acc_p0_q[l]);
      row_p1_d[l*PIXEL_W +: PIXEL_W] = clip_pix(r);
`ifdef SUBPEL_SAT_CNT_EN
      clip_p1_d[l] = (r < 0) || (r > $signed(ACC_W'(PIX_MAX)));
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      out_cnt_q <= '0;
      frac_q    <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      out_cnt_q <= out_cnt_d;
      frac_q    <= frac_d;
      rdy_en_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < TAPS; t++) win_q[t] <= '0;
      for (int l = 0; l < NUM_PIXEL; l++) acc_p0_q[l] <= '0;
      vld_p0_q <= 1'b0;
      row_p1_q <= '0;
      vld_p1_q <= 1'b0;
`ifdef SUBPEL_SAT_CNT_EN
      clip_p1_q <= '0;
`endif
    end else begin
      if (in_acc)
        for (int t = 0; t < TAPS; t++) win_q[t] <= src[t];
      // p0: MAC result; p1: rounded and clipped row. Both hold while adv is low.
      if (adv) begin
        vld_p0_q <= launch;
        if (launch)
          for (int l = 0; l < NUM_PIXEL; l++) acc_p0_q[l] <= mac_d[l];
        vld_p1_q <= vld_p0_q;
        if (vld_p0_q) begin
          row_p1_q <= row_p1_d;
`ifdef SUBPEL_SAT_CNT_EN
          clip_p1_q <= clip_p1_d;
`endif
        end
      end
    end
  end

`ifdef SUBPEL_SAT_CNT_EN
  always_comb begin
    sat_sum   = {1'b0, sat_cnt_q} + 17'($countones(clip_p1_q));
    sat_cnt_d = sat_cnt_q;
    if (out_acc) sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sat_cnt_q <= '0;
    else      sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_vert_subpel_filter.sv
// Directed-vector bench for vert_subpel_filter: constant, ramp, clip, backpressure, reset, back-to-back.
module tb_vert_subpel_filter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_row = '0;
  logic [1:0]  frac_sel = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_row;
  logic        block_done;
  logic        busy;
`ifdef SUBPEL_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  vert_subpel_filter #(.NUM_PIXEL(8), .PIXEL_W(8), .BLK_ROWS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .frac_sel(frac_sel), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .block_done(block_done), .busy(busy)
`ifdef SUBPEL_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  logic [63:0] rows [32];
  logic [1:0]  frs  [32];
  logic [63:0] got  [16];
  int n_got, n_done, lat, low_in, viol, timed_out;

  function automatic logic [63:0] mk_row(input int v, input int inc);
    logic [63:0] r;
    for (int l = 0; l < 8; l++) r[l*8 +: 8] = 8'(v + l*inc);
    return r;
  endfunction

  // Streams nblk blocks from rows/frs and records what the DUT returns.
  task automatic drive(input int nblk, input int rmode);
    int ri = 0;
    int cyc = 0;
    int acc8 = -1;
    int first_ov = -1;
    logic prev_stall = 1'b0;
    logic [63:0] prev_row = '0;
    n_got = 0; n_done = 0; lat = -1; low_in = 0; viol = 0; timed_out = 0;
    while ((n_got < 8*nblk || n_done < nblk) && cyc < 2000) begin
      @(negedge clk);
      in_valid = (ri < 15*nblk);
      in_row   = in_valid ? rows[ri] : '0;
      frac_sel = in_valid ? frs[ri] : 2'd0;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 2) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (out_valid && prev_stall && out_row !== prev_row) viol++;
      if (out_valid && !out_ready && in_ready) viol++;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (block_done) n_done++;
      if (out_valid && out_ready) begin
        if (n_got < 16) got[n_got] = out_row;
        n_got++;
      end
      if (in_valid && !in_ready && out_ready) low_in++;
      prev_stall = out_valid && !out_ready;
      prev_row   = out_row;
      if (in_valid && in_ready) begin
        if (ri == 7) acc8 = cyc;
        ri++;
      end
      cyc++;
    end
    if (n_got < 8*nblk || n_done < nblk) timed_out = 1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    lat = (acc8 >= 0 && first_ov >= 0) ? first_ov - acc8 : -1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_row = mk_row(100, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    nvec++;
    if ({in_ready, out_valid, block_done, busy} !== 4'b0000) begin
      $display("FAIL reset_ctrl: got %b expected 0000", {in_ready, out_valid, block_done, busy});
      nerr++;
    end
    nvec++;
    if (out_row !== 64'h0) begin
      $display("FAIL reset_row: got %h expected 0", out_row);
      nerr++;
    end
`ifdef SUBPEL_SAT_CNT_EN
    nvec++;
    if (sat_cnt !== 16'h0) begin
      $display("FAIL reset_sat: got %h expected 0", sat_cnt);
      nerr++;
    end
`endif
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_const();
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < 15; r++) begin rows[r] = mk_row(100, 0); frs[r] = 2'(f); end
      drive(1, 0);
      for (int k = 0; k < 8; k++) begin
        nvec++;
        if (got[k] !== mk_row(100, 0)) begin
          $display("FAIL const_f%0d_row%0d: got %h expected %h", f, k, got[k], mk_row(100, 0));
          nerr++;
        end
      end
      nvec++;
      if (lat !== 2) begin $display("FAIL const_latency: got %0d expected 2", lat); nerr++; end
      nvec++;
      if (n_done !== 1 || n_got !== 8 || timed_out !== 0) begin
        $display("FAIL const_counts: done %0d outs %0d timeout %0d expected 1 8 0", n_done, n_got, timed_out);
        nerr++;
      end
      nvec++;
      if (low_in !== 0) begin $display("FAIL const_in_ready: got %0d low cycles expected 0", low_in); nerr++; end
      @(negedge clk);
      nvec++;
      if (busy !== 1'b0) begin $display("FAIL const_busy_end: got %b expected 0", busy); nerr++; end
    end
  endtask

  task automatic test_ramp();
    for (int r = 0; r < 15; r++) begin rows[r] = mk_row(10*r, 1); frs[r] = 2'd3; end
    drive(1, 0);
    for (int k = 0; k < 8; k++) begin
      nvec++;
      if (got[k] !== mk_row(10*(k+3), 1)) begin
        $display("FAIL ramp_full_row%0d: got %h expected %h", k, got[k], mk_row(10*(k+3), 1));
        nerr++;
      end
    end
    for (int r = 0; r < 15; r++) frs[r] = 2'd1;
    drive(1, 0);
    for (int k = 0; k < 8; k++) begin
      nvec++;
      if (got[k] !== mk_row(10*k + 35, 1)) begin
        $display("FAIL ramp_half_row%0d: got %h expected %h", k, got[k], mk_row(10*k + 35, 1));
        nerr++;
      end
    end
  endtask

  task automatic test_clip();
    int hi_exp [8] = '{255, 68, 131, 171, 0, 16, 0, 0};
    int lo_exp [8] = '{0, 191, 112, 116, 175, 0, 16, 0};
`ifdef SUBPEL_SAT_CNT_EN
    logic [15:0] s0;
`endif
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 15; r++) begin
        logic hot;
        hot = (r == 1 || r == 3 || r == 4 || r == 6);
        if (p == 1) hot = (r == 0 || r == 2 || r == 5 || r == 7);
        rows[r] = hot ? mk_row(255, 0) : 64'h0;
        frs[r]  = 2'd1;
      end
`ifdef SUBPEL_SAT_CNT_EN
      s0 = sat_cnt;
`endif
      drive(1, 0);
      for (int k = 0; k < 8; k++) begin
        int e;
        e = (p == 0) ? hi_exp[k] : lo_exp[k];
        nvec++;
        if (got[k] !== mk_row(e, 0)) begin
          $display("FAIL clip_p%0d_row%0d: got %h expected %h", p, k, got[k], mk_row(e, 0));
          nerr++;
        end
      end
      @(negedge clk);
`ifdef SUBPEL_SAT_CNT_EN
      nvec++;
      if (sat_cnt - s0 !== 16'd24) begin
        $display("FAIL clip_sat_p%0d: got +%0d expected +24", p, sat_cnt - s0);
        nerr++;
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    for (int m = 1; m < 3; m++) begin
      for (int r = 0; r < 15; r++) begin rows[r] = mk_row(10*r, 1); frs[r] = 2'd1; end
      drive(1, m);
      for (int k = 0; k < 8; k++) begin
        nvec++;
        if (got[k] !== mk_row(10*k + 35, 1)) begin
          $display("FAIL bp_m%0d_row%0d: got %h expected %h", m, k, got[k], mk_row(10*k + 35, 1));
          nerr++;
        end
      end
      nvec++;
      if (viol !== 0) begin $display("FAIL bp_stall_m%0d: got %0d violations expected 0", m, viol); nerr++; end
      nvec++;
      if (n_done !== 1 || n_got !== 8 || timed_out !== 0) begin
        $display("FAIL bp_counts_m%0d: done %0d outs %0d timeout %0d expected 1 8 0", m, n_done, n_got, timed_out);
        nerr++;
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_row = mk_row(200, 0); frac_sel = 2'd0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    nvec++;
    if (busy !== 1'b1) begin $display("FAIL midfill_busy: got %b expected 1", busy); nerr++; end
    rst = 1'b0;
    #1;
    nvec++;
    if ({in_ready, out_valid, block_done, busy} !== 4'b0000 || out_row !== 64'h0) begin
      $display("FAIL midfill_reset: ctrl %b row %h expected 0000 0", {in_ready, out_valid, block_done, busy}, out_row);
      nerr++;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int r = 0; r < 15; r++) begin rows[r] = mk_row(10*r, 1); frs[r] = 2'd3; end
    drive(1, 0);
    for (int k = 0; k < 8; k++) begin
      nvec++;
      if (got[k] !== mk_row(10*(k+3), 1)) begin
        $display("FAIL midfill_row%0d: got %h expected %h", k, got[k], mk_row(10*(k+3), 1));
        nerr++;
      end
    end
    nvec++;
    if (lat !== 2 || n_got !== 8 || n_done !== 1) begin
      $display("FAIL midfill_counts: lat %0d outs %0d done %0d expected 2 8 1", lat, n_got, n_done);
      nerr++;
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 15; r++) begin
      rows[r]    = mk_row(10*r, 1);
      rows[r+15] = mk_row(10*r, 1);
      frs[r]     = (r == 0) ? 2'd1 : 2'd2;
      frs[r+15]  = (r == 0) ? 2'd0 : 2'd3;
    end
    drive(2, 0);
    for (int k = 0; k < 8; k++) begin
      nvec++;
      if (got[k] !== mk_row(10*k + 35, 1)) begin
        $display("FAIL b2b_blkB_row%0d: got %h expected %h", k, got[k], mk_row(10*k + 35, 1));
        nerr++;
      end
      nvec++;
      if (got[k+8] !== mk_row(10*k + 32, 1)) begin
        $display("FAIL b2b_blkA_row%0d: got %h expected %h", k, got[k+8], mk_row(10*k + 32, 1));
        nerr++;
      end
    end
    nvec++;
    if (n_done !== 2 || timed_out !== 0) begin
      $display("FAIL b2b_done: got %0d timeout %0d expected 2 0", n_done, timed_out);
      nerr++;
    end
    nvec++;
    if (low_in !== 2) begin $display("FAIL b2b_in_ready_low: got %0d expected 2", low_in); nerr++; end
  endtask

  initial begin
    test_reset();
    test_const();
    test_ramp();
    test_clip();
    test_backpressure();
    test_reset_mid_fill();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vert_subpel_filter.md
Name: vert_subpel_filter

Overview:
- Vertical luma sub-pixel interpolation stage. Sits directly downstream of the horizontal half/quarter-pel FIR stage.
- Consumes one 8-pixel row of horizontally filtered samples per accepted beat and keeps a sliding 8-row window.
- Applies the HEVC 8-tap vertical filter selected per block and emits one clipped 8-pixel output row per beat once the window is full.
- Output rows go to the output packer.

Parameters:
- NUM_PIXEL, 8, pixels per row (lanes)
- PIXEL_W, 8, bits per input/output pixel
- BLK_ROWS, 8, output rows per block; input rows per block = BLK_ROWS+7

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  in_row valid
- in_ready  out  1  stage accepts in_row this cycle
- in_row  in  NUM_PIXEL*PIXEL_W  8 pixels, lane i at [i*PIXEL_W +: PIXEL_W], unsigned
- frac_sel  in  2  0=quarter (A), 1=half (B), 2=three-quarter (C), 3=full-pel; sampled on first row of block
- out_valid  out  1  out_row valid
- out_ready  in  1  downstream accepts out_row
- out_row  out  NUM_PIXEL*PIXEL_W  filtered row, same lane packing
- block_done  out  1  one-cycle pulse when last output row of block is accepted
- busy  out  1  high from first accepted row until block_done

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, window, row/output counters and pipeline cleared. Deassertion takes effect on the next clk edge.
- Handshake: input beat on in_valid&in_ready; output beat on out_valid&out_ready. adv = !out_valid | out_ready; in_ready = adv & (state!=DRAIN).
- out_valid/out_row hold stable while out_ready=0.
- FSM:
  - IDLE: first accepted row latches frac_sel, row_cnt=1, go FILL.
  - FILL: accept rows; when row_cnt reaches 7 go RUN. No outputs.
  - RUN: each accepted row shifts the window (oldest out) and launches one output computation. After input row BLK_ROWS+7 is accepted go DRAIN.
  - DRAIN: in_ready=0; wait until the last output beat is accepted, pulse block_done, go IDLE.
  - The next block's first row may be accepted the cycle after block_done.
- Window: rows w0 (oldest) .. w7 (newest). Output k uses input rows k..k+7.
- Taps, w0..w7:
  - A: -1,4,-10,58,17,-5,1,0
  - B: -1,4,-11,40,40,-11,4,-1
  - C: 0,1,-5,17,58,-10,4,-1
  - full-pel: 0,0,0,64,0,0,0,0
- Arithmetic: per lane, 16-bit signed accumulate; res = (acc+32)>>>6; clip to [0,255].
- Pipeline: 2 stages (MAC, round/clip). out_valid rises 2 adv-cycles after the row completing the window is accepted. Full throughput of 1 row/cycle when out_ready=1.
- Backpressure: the whole pipeline freezes while adv=0; no row is lost or duplicated.
- frac_sel changes mid-block are ignored.
- in_valid in DRAIN is ignored (in_ready=0).
- Counters: row_cnt wraps to 0 at block end; out_cnt counts accepted outputs 0..BLK_ROWS-1.

Optional Feature:
- Macro: SUBPEL_SAT_CNT_EN.
- Defined: adds output port sat_cnt (16 bits, reset 0). It counts lanes clipped (res<0 or res>255) on each accepted output beat, adding 0..NUM_PIXEL per beat, saturating at 16'hFFFF. Cleared only by reset.
- Undefined: port and logic absent; datapath behaviour identical.

Test Plan:
- Constant rows 100, frac_sel=0,1,2,3 in turn, out_ready=1 -> 8 output rows per block, every pixel 100; first out_valid 2 cycles after 8th input row; block_done once per block.
- Ramp: lane0 row r = 10*r, frac_sel=3 -> output k lane0 = 10*(k+3); frac_sel=1 -> output k lane0 = 10*k+35.
- Clip: frac_sel=1, rows 1,3,4,6 of window =255, others 0 -> out 255. Inverted pattern -> out 0. With SUBPEL_SAT_CNT_EN, sat_cnt +8 per clipped row.
- Backpressure: out_ready toggling 1010... and random -> output sequence identical to out_ready=1 run; out_row stable while stalled; in_ready=0 whenever out_valid&!out_ready.
- Reset mid-FILL after 4 rows, then full new block -> no outputs from partial block; new block outputs correct; all outputs 0 during reset.
- Back-to-back blocks, B then A, in_valid held 1 -> in_ready low only in DRAIN; frac change inside a block ignored; second block uses A taps.
